// File: rtl/ingress_pkg.sv
// Shared types and constants for the ingress frame path (arbiter, buffer writer, egress reuse).
package ingress_pkg;

    localparam int unsigned WORDS_PER_SLOT = 128;
    localparam int unsigned MAX_FRAME_SIZE = 1522;
    localparam int unsigned MAX_SLOT_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        DESC
    } arb_state_t;

    typedef struct packed {
        logic [3:0]               port;
        logic [11:0]              vlan;
        logic [10:0]              bytelen;
        logic [MAX_SLOT_BITS-1:0] slot;
        logic                     error;
    } ingress_desc_t;

    // 128-bit words needed to carry bytelen bytes, rounded up.
    function automatic logic [7:0] expected_words(input logic [10:0] bytelen);
        return {1'b0, bytelen[10:4]} + {7'd0, |bytelen[3:0]};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_BITS  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_BITS-1:0]  ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_BITS-1:0]  idx,
    output logic                 any
);

    int unsigned          cand;
    logic [IDX_BITS-1:0]  cand_idx;

    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand     = (32'(ptr) + k) % NUM_PORTS;
            cand_idx = IDX_BITS'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                idx             = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ingress_frame_arbiter.sv
// Round-robin frame arbiter: grants one ingress port at a time, writes its words into a
// free-list slot of the packet buffer and emits a descriptor when the frame ends.
module ingress_frame_arbiter
    import ingress_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned SLOT_BITS = 6
) (
    input  logic                       clk_mem,
    input  logic                       rst,
    input  logic [NUM_PORTS-1:0]       port_frame_ready,
    input  logic [NUM_PORTS*11-1:0]    port_frame_bytelen,
    input  logic [NUM_PORTS*12-1:0]    port_frame_vlan,
    input  logic [NUM_PORTS-1:0]       port_valid,
    input  logic [NUM_PORTS*128-1:0]   port_data,
    input  logic [NUM_PORTS-1:0]       port_frame_done,
    output logic [NUM_PORTS-1:0]       port_frame_start,
    input  logic                       slot_valid,
    input  logic [SLOT_BITS-1:0]       slot_id,
    output logic                       slot_pop,
    output logic                       buf_wr_en,
    output logic [SLOT_BITS+6:0]       buf_wr_addr,
    output logic [127:0]               buf_wr_data,
    output logic                       desc_valid,
    input  logic                       desc_ready,
    output logic [3:0]                 desc_port,
    output logic [11:0]                desc_vlan,
    output logic [10:0]                desc_bytelen,
    output logic [SLOT_BITS-1:0]       desc_slot,
    output logic                       desc_error,
    output logic [31:0]                frames_forwarded
);

    localparam int unsigned IDX_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_t              state;
    logic [IDX_BITS-1:0]     rr_ptr;
    logic [IDX_BITS-1:0]     win;
    logic [NUM_PORTS-1:0]    win_onehot;
    logic [10:0]             cur_bytelen;
    logic [11:0]             cur_vlan;
    logic [SLOT_BITS-1:0]    cur_slot;
    logic [7:0]              idx;
    logic                    ovf;
    ingress_desc_t           desc;
    logic [MAX_SLOT_BITS-1:0] desc_slot_full_unused;

    logic [NUM_PORTS-1:0]    arb_grant;
    logic [IDX_BITS-1:0]     arb_idx;
    logic                    arb_any;

    logic                    win_valid;
    logic                    win_done;
    logic [127:0]            win_data;
    logic [10:0]             arb_bytelen;
    logic [11:0]             arb_vlan;

    logic                    in_frame;
    logic [7:0]              word_base;
    logic                    word_take;
    logic                    word_write;
    logic [7:0]              idx_next;
    logic                    ovf_next;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_BITS  (IDX_BITS)
    ) u_rr_arbiter (
        .req   (port_frame_ready),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        win_valid   = 1'b0;
        win_done    = 1'b0;
        win_data    = '0;
        arb_bytelen = '0;
        arb_vlan    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (32'(win) == p) begin
                win_valid = port_valid[p];
                win_done  = port_frame_done[p];
                win_data  = port_data[p*128 +: 128];
            end
            if (32'(arb_idx) == p) begin
                arb_bytelen = port_frame_bytelen[p*11 +: 11];
                arb_vlan    = port_frame_vlan[p*12 +: 12];
            end
        end
    end

    // START restarts the word count, so its word lands at index 0 regardless of stale idx.
    always_comb begin
        in_frame   = (state == START) || (state == DATA);
        word_base  = (state == START) ? 8'd0 : idx;
        word_take  = in_frame && win_valid;
        word_write = word_take && !word_base[7];
        idx_next   = word_write ? word_base + 8'd1 : word_base;
        ovf_next   = ((state == DATA) && ovf) || (word_take && word_base[7]);
    end

    assign port_frame_start      = (state == START) ? win_onehot : '0;
    assign desc_port             = desc.port;
    assign desc_vlan             = desc.vlan;
    assign desc_bytelen          = desc.bytelen;
    assign desc_slot             = desc.slot[SLOT_BITS-1:0];
    assign desc_error            = desc.error;
    assign desc_slot_full_unused = desc.slot;

    always_ff @(posedge clk_mem) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= IDX_BITS'(NUM_PORTS - 1);
            win              <= '0;
            win_onehot       <= '0;
            cur_bytelen      <= '0;
            cur_vlan         <= '0;
            cur_slot         <= '0;
            idx              <= '0;
            ovf              <= 1'b0;
            slot_pop         <= 1'b0;
            buf_wr_en        <= 1'b0;
            buf_wr_addr      <= '0;
            buf_wr_data      <= '0;
            desc             <= '0;
            desc_valid       <= 1'b0;
            frames_forwarded <= '0;
        end else begin
            slot_pop  <= 1'b0;
            buf_wr_en <= word_write;
            if (word_write) begin
                buf_wr_addr <= {cur_slot, word_base[6:0]};
                buf_wr_data <= win_data;
            end
            case (state)
                IDLE: begin
                    if (arb_any && slot_valid && !desc_valid) begin
                        win         <= arb_idx;
                        win_onehot  <= arb_grant;
                        rr_ptr      <= arb_idx;
                        cur_bytelen <= arb_bytelen;
                        cur_vlan    <= arb_vlan;
                        cur_slot    <= slot_id;
                        slot_pop    <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    idx   <= idx_next;
                    ovf   <= ovf_next;
                    state <= DATA;
                end
                DATA: begin
                    idx <= idx_next;
                    ovf <= ovf_next;
                    if (win_done) begin
                        desc.port    <= 4'(win);
                        desc.vlan    <= cur_vlan;
                        desc.bytelen <= cur_bytelen;
                        desc.slot    <= MAX_SLOT_BITS'(cur_slot);
                        desc.error   <= ovf_next || (idx_next != expected_words(cur_bytelen));
                        desc_valid   <= 1'b1;
                        state        <= DESC;
                    end
                end
                DESC: begin
                    if (desc_ready) begin
                        desc_valid <= 1'b0;
                        if (frames_forwarded != '1) begin
                            frames_forwarded <= frames_forwarded + 32'd1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ingress_frame_arbiter.md
Name: ingress_frame_arbiter

Overview:
- Sits in the clk_mem domain, directly downstream of the per-port ingress CDC blocks.
- Picks one port at a time with a round-robin arbiter, pulses that port's frame_start and drains its 128-bit frame words into the shared packet buffer. Each frame goes into a fixed 2 kB slot taken from an external free list.
- When the frame ends, emits a descriptor (port, VLAN, byte length, slot) to the forwarding logic.
- Upstream word stream cannot be back-pressured, so buffer writes are unconditional.

Parameters:
- NUM_PORTS, 4, number of ingress ports arbitrated (2..16).
- SLOT_BITS, 6, log2 of the number of buffer slots; buffer address width is SLOT_BITS+7.
- WORDS_PER_SLOT, 128, 128-bit words per slot (2048 bytes); fixed, not overridable.

Ports:
- clk_mem  in  1  memory-domain clock.
- rst  in  1  synchronous active-high reset.
- port_frame_ready  in  NUM_PORTS  per-port header-available flag.
- port_frame_bytelen  in  NUM_PORTS*11  packed per-port frame length in bytes.
- port_frame_vlan  in  NUM_PORTS*12  packed per-port VLAN ID.
- port_valid  in  NUM_PORTS  per-port data word valid.
- port_data  in  NUM_PORTS*128  packed per-port data word.
- port_frame_done  in  NUM_PORTS  per-port end-of-frame pulse, one cycle after the last word.
- port_frame_start  out  NUM_PORTS  one-hot single-cycle grant pulse.
- slot_valid  in  1  free list has a slot.
- slot_id  in  SLOT_BITS  head of free list.
- slot_pop  out  1  consume slot_id this cycle.
- buf_wr_en  out  1  buffer write strobe.
- buf_wr_addr  out  SLOT_BITS+7  {slot, word index}.
- buf_wr_data  out  128  write data.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  descriptor consumer accepts.
- desc_port  out  4  source port index.
- desc_vlan  out  12  VLAN ID.
- desc_bytelen  out  11  frame length in bytes.
- desc_slot  out  SLOT_BITS  slot holding the frame.
- desc_error  out  1  word count did not match bytelen, or slot overflow.
- frames_forwarded  out  32  saturating count of descriptors accepted.

Behaviour:
- Reset values: all outputs 0. FSM=IDLE. Round-robin pointer=NUM_PORTS-1.
- Reset mid-frame: return to IDLE and drop the in-flight frame. The popped slot is not returned; the free list is reset by the same rst.
- FSM states: IDLE, START, DATA, DESC.
- IDLE -> START:
  - Condition: any port_frame_ready, slot_valid=1 and desc_valid=0.
  - Winner is the first ready port searching from pointer+1 with wrap-around.
  - Registered on this edge: winner index, bytelen, vlan and slot_id; pointer updated to the winner; slot_pop=1 for exactly one cycle.
- START (exactly one cycle):
  - port_frame_start[winner]=1 combinationally; word index cleared.
  - The upstream may present valid in this same cycle, so port_valid[winner] is already accepted here.
  - START -> DATA unconditionally.
- Word handling in START/DATA:
  - Every cycle port_valid[winner]=1: register buf_wr_en=1, buf_wr_addr={slot, idx[6:0]}, buf_wr_data=word, then idx++. Write latency is 1 cycle.
  - idx is 8 bits. If idx reaches 128, further words are discarded (no write) and an overflow flag is set.
  - valid and data from non-granted ports are ignored.
- DATA -> DESC on port_frame_done[winner]:
  - desc_valid=1 next cycle with the latched fields.
  - expected words = ceil(bytelen/16) = bytelen[10:4] + |bytelen[3:0].
  - desc_error = overflow OR (idx != expected words).
- DESC: hold all desc_* stable while desc_valid && !desc_ready. On the accepting cycle, frames_forwarded++ (saturating at 2^32-1) and DESC -> IDLE.
- Issue rate: a new grant is possible the cycle after acceptance, so the minimum frame-to-frame gap is 1 idle cycle.
- Simultaneous events:
  - port_frame_done in the same cycle as a valid word: write the word, then go to DESC with the word counted.
  - slot_valid dropping during a frame has no effect.
  - Ready ports with slot_valid=0 stay in IDLE and no pointer change occurs.
- Bytelen 0 frame: expected words 0. A done without words gives desc_error=0.

Decomposition:
- Shared package ingress_pkg: typedef ingress_desc_t {port, vlan, bytelen, slot, error}, and constants WORDS_PER_SLOT and MAX_FRAME_SIZE=1522.
- Sub-module rr_arbiter (NUM_PORTS request vector, pointer in, one-hot grant and index out, purely combinational). Reusable by egress.

Test Plan:
- Port 2 only, bytelen 64: grant pulse port 2; 4 writes at addr {slot,0..3}; desc_valid with port=2, bytelen=64, error=0; slot_pop once.
- Ports 0,1,3 ready continuously, pointer reset: grants in order 0,1,3,0; frames_forwarded=4 after 4 accepted descriptors.
- Bytelen 65 but only 4 words then done: desc_error=1. Bytelen 65 with 5 words: error=0, last write at word index 4.
- desc_ready low for 10 cycles while port 1 is ready: no port_frame_start and no slot_pop until acceptance; desc fields stable throughout.
- 130 words pushed into one frame: exactly 128 writes (idx 0..127), desc_error=1.
- rst asserted mid-DATA, then port 0 frame of 32 bytes: all outputs 0 the cycle after rst; next frame completes normally with 2 writes at {new slot,0..1}.
